// File: rtl/render_ctrl.sv
// rtl/render_ctrl.sv - drawing sequencer: full-screen copy, board redraw and single-tile redraw into one plot stream
module render_ctrl #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120,
    parameter int COLS     = 20,
    parameter int ROWS     = 15
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        screen_req,
    input  logic        board_req,
    input  logic        tile_req,
    input  logic [4:0]  tile_col,
    input  logic [3:0]  tile_row,
    output logic        busy,
    output logic        done,
    output logic [14:0] screen_addr,
    input  logic [2:0]  screen_pix,
    output logic [8:0]  map_addr,
    input  logic [1:0]  map_code,
    output logic [1:0]  sprite_sel,
    output logic [5:0]  sprite_addr,
    input  logic [2:0]  sprite_pix,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot
);

    typedef enum logic [2:0] {IDLE, SCR, MAP_RD, MAP_WAIT, SPR, FIN} state_t;

    state_t     state, state_n;
    logic [7:0] x;
    logic [6:0] y;
    logic [4:0] col;
    logic [3:0] row;
    logic [5:0] spr;
    logic [1:0] sel;
    logic       board_mode;
    logic       scr_mode;

    logic       tile_ok;
    logic       last_x, last_y, last_col, last_row, last_spr;
    logic [7:0] px;
    logic [6:0] py;
    logic       pvalid;

    assign tile_ok  = (tile_col < 5'(COLS)) && (tile_row < 4'(ROWS));
    assign last_x   = (x == 8'(SCREEN_W - 1));
    assign last_y   = (y == 7'(SCREEN_H - 1));
    assign last_col = (col == 5'(COLS - 1));
    assign last_row = (row == 4'(ROWS - 1));
    assign last_spr = (spr == 6'd63);

    // Addresses are pure functions of the walk counters; 160 = 128+32 and 20 = 16+4
    assign screen_addr = 15'({y, 7'b0}) + 15'({y, 5'b0}) + 15'(x);
    assign map_addr    = 9'({row, 4'b0}) + 9'({row, 2'b0}) + 9'(col);
    assign sprite_addr = spr;
    assign sprite_sel  = sel;
    assign busy        = (state != IDLE);
    assign vga_colour  = scr_mode ? screen_pix : sprite_pix;

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Next-state: accept one request from IDLE by priority, then walk it to FIN
    always_comb begin
        state_n = state;
        case (state)
            IDLE: begin
                if (screen_req)                          state_n = SCR;
                else if (board_req || (tile_req && tile_ok)) state_n = MAP_RD;
            end
            SCR:      if (last_x && last_y) state_n = FIN;
            MAP_RD:   state_n = MAP_WAIT;
            MAP_WAIT: state_n = SPR;
            SPR: begin
                if (last_spr)
                    state_n = (!board_mode || (last_col && last_row)) ? FIN : MAP_RD;
            end
            FIN:      state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end

    // Walk counters, mode flags and the latched tile code
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            x          <= '0;
            y          <= '0;
            col        <= '0;
            row        <= '0;
            spr        <= '0;
            sel        <= '0;
            board_mode <= 1'b0;
            scr_mode   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (screen_req) begin
                        scr_mode <= 1'b1;
                        x        <= '0;
                        y        <= '0;
                    end else if (board_req) begin
                        scr_mode   <= 1'b0;
                        board_mode <= 1'b1;
                        col        <= '0;
                        row        <= '0;
                    end else if (tile_req && tile_ok) begin
                        scr_mode   <= 1'b0;
                        board_mode <= 1'b0;
                        col        <= tile_col;
                        row        <= tile_row;
                    end
                end
                SCR: begin
                    if (last_x) begin
                        x <= '0;
                        y <= last_y ? 7'd0 : y + 7'd1;
                    end else begin
                        x <= x + 8'd1;
                    end
                end
                MAP_WAIT: begin
                    sel <= map_code;
                    spr <= '0;
                end
                SPR: begin
                    spr <= spr + 6'd1;
                    // Board walk advances row-major; the final tile leaves the counters parked
                    if (last_spr && board_mode && !(last_col && last_row)) begin
                        if (last_col) begin
                            col <= '0;
                            row <= row + 4'd1;
                        end else begin
                            col <= col + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Pixel coordinate for the address currently presented to the ROMs
    always_comb begin
        px     = x;
        py     = y;
        pvalid = 1'b0;
        if (state == SCR) begin
            pvalid = 1'b1;
        end else if (state == SPR) begin
            px     = {col, 3'b000} + {5'b0, spr[2:0]};
            py     = {row, 3'b000} + {4'b0, spr[5:3]};
            pvalid = 1'b1;
        end
    end

    // Plot stage lines up with ROM read latency; done follows the FIN cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            vga_x    <= '0;
            vga_y    <= '0;
            vga_plot <= 1'b0;
            done     <= 1'b0;
        end else begin
            vga_x    <= px;
            vga_y    <= py;
            vga_plot <= pvalid;
            done     <= (state == FIN);
        end
    end

endmodule

// File: tb/tb_render_ctrl.sv
// tb/tb_render_ctrl.sv - self-checking bench for render_ctrl
module tb_render_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        screen_req, board_req, tile_req;
    logic [4:0]  tile_col;
    logic [3:0]  tile_row;
    logic        busy, done;
    logic [14:0] screen_addr;
    logic [2:0]  screen_pix;
    logic [8:0]  map_addr;
    logic [1:0]  map_code;
    logic [1:0]  sprite_sel;
    logic [5:0]  sprite_addr;
    logic [2:0]  sprite_pix;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;

    render_ctrl dut (
        .clock(clock), .reset(reset),
        .screen_req(screen_req), .board_req(board_req), .tile_req(tile_req),
        .tile_col(tile_col), .tile_row(tile_row),
        .busy(busy), .done(done),
        .screen_addr(screen_addr), .screen_pix(screen_pix),
        .map_addr(map_addr), .map_code(map_code),
        .sprite_sel(sprite_sel), .sprite_addr(sprite_addr), .sprite_pix(sprite_pix),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clock = ~clock;

    logic [1:0] map_mem [0:511];
    bit         seen    [0:19199];

    // Synchronous ROM/RAM models: data valid the cycle after the address
    always @(posedge clock) begin
        screen_pix <= screen_addr[2:0];
        map_code   <= map_mem[map_addr];
        sprite_pix <= 3'(sprite_addr[5:3] + sprite_addr[2:0] + {1'b0, sprite_sel});
    end

    int checks = 0;
    int errors = 0;
    int nplot, nbad, ndone, done_cyc, nsel_bad, ndup;
    int map_at1, busy_at1, sel_at3, scr_at1;

    typedef struct {
        int col;
        int row;
        int code;
        int valid;
        int exp_map;
    } tvec_t;
    tvec_t tv [7];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic issue(input logic s, input logic b, input logic t, input int c, input int r);
        screen_req = s;
        board_req  = b;
        tile_req   = t;
        tile_col   = 5'(c);
        tile_row   = 4'(r);
        @(negedge clock);
        screen_req = 1'b0;
        board_req  = 1'b0;
        tile_req   = 1'b0;
    endtask

    // mode: 0 screen, 1 single tile, 2 board, 3 nothing expected
    task automatic watch(input int mode, input int budget, input int tc, input int tr,
                         input int tcode, input int inject_rel);
        int k, n, j, ec, ex, ey, erel, pr, pc, code;
        logic busy_prev;
        nplot = 0; nbad = 0; ndone = 0; done_cyc = -1; nsel_bad = 0; ndup = 0;
        busy_prev = 1'b0;
        for (int rel = 1; rel <= budget; rel++) begin
            if (rel == 1) begin
                map_at1  = int'(map_addr);
                busy_at1 = int'(busy);
                scr_at1  = int'(screen_addr);
            end
            if (rel == 3) sel_at3 = int'(sprite_sel);
            if (mode == 2 && rel >= 3 && ((rel - 3) % 66) < 64 && ((rel - 3) / 66) < 300) begin
                n = (rel - 3) / 66;
                if (int'(sprite_sel) != ((n / 20 + n % 20) % 4)) nsel_bad++;
            end
            if (vga_plot) begin
                k = nplot;
                case (mode)
                    0: begin ex = k % 160; ey = k / 160; ec = k % 8; erel = 2 + k; end
                    1: begin
                        ex = tc * 8 + k % 8; ey = tr * 8 + k / 8;
                        ec = (k / 8 + k % 8 + tcode) % 8; erel = 4 + k;
                    end
                    2: begin
                        n = k / 64; j = k % 64; pr = n / 20; pc = n % 20; code = (pr + pc) % 4;
                        ex = pc * 8 + j % 8; ey = pr * 8 + j / 8;
                        ec = (j / 8 + j % 8 + code) % 8; erel = 4 + 66 * n + j;
                    end
                    default: begin ex = -1; ey = -1; ec = -1; erel = -1; end
                endcase
                if (int'(vga_x) != ex || int'(vga_y) != ey || int'(vga_colour) != ec || rel != erel)
                    nbad++;
                if (mode == 2) begin
                    if (vga_x < 8'd160 && vga_y < 7'd120) begin
                        if (seen[int'(vga_y) * 160 + int'(vga_x)]) ndup++;
                        seen[int'(vga_y) * 160 + int'(vga_x)] = 1'b1;
                    end else begin
                        ndup++;
                    end
                end
                nplot++;
            end
            if (done) begin
                ndone++;
                if (done_cyc < 0) done_cyc = rel;
                if (busy || !busy_prev) nbad++;
            end
            busy_prev = busy;
            if (inject_rel >= 0) tile_req = (rel == inject_rel);
            @(negedge clock);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"},  int'(busy), 0);
        check({tag, "_done"},  int'(done), 0);
        check({tag, "_plot"},  int'(vga_plot), 0);
        check({tag, "_x"},     int'(vga_x), 0);
        check({tag, "_y"},     int'(vga_y), 0);
        check({tag, "_saddr"}, int'(screen_addr), 0);
        check({tag, "_maddr"}, int'(map_addr), 0);
        check({tag, "_paddr"}, int'(sprite_addr), 0);
        check({tag, "_sel"},   int'(sprite_sel), 0);
    endtask

    initial begin
        tv[0] = '{col: 19, row: 14, code: 3, valid: 1, exp_map: 299};
        tv[1] = '{col: 0,  row: 0,  code: 0, valid: 1, exp_map: 0};
        tv[2] = '{col: 5,  row: 7,  code: 2, valid: 1, exp_map: 145};
        tv[3] = '{col: 10, row: 3,  code: 1, valid: 1, exp_map: 70};
        tv[4] = '{col: 20, row: 0,  code: 0, valid: 0, exp_map: 0};
        tv[5] = '{col: 0,  row: 15, code: 0, valid: 0, exp_map: 0};
        tv[6] = '{col: 31, row: 15, code: 0, valid: 0, exp_map: 0};
        for (int i = 0; i < 512; i++) map_mem[i] = 2'd0;

        reset = 1'b1; screen_req = 1'b0; board_req = 1'b0; tile_req = 1'b0;
        tile_col = '0; tile_row = '0;
        repeat (3) @(negedge clock);
        check_zero("rst");
        reset = 1'b0;
        @(negedge clock);

        // Full screen copy
        issue(1'b1, 1'b0, 1'b0, 0, 0);
        watch(0, 19210, 0, 0, 0, -1);
        check("scr_busy1", busy_at1, 1);
        check("scr_addr1", scr_at1, 0);
        check("scr_nplot", nplot, 19200);
        check("scr_bad", nbad, 0);
        check("scr_done_cyc", done_cyc, 19202);
        check("scr_ndone", ndone, 1);
        check("scr_busy_end", int'(busy), 0);

        // Single-tile table
        foreach (tv[i]) begin
            if (tv[i].valid != 0) map_mem[tv[i].row * 20 + tv[i].col] = 2'(tv[i].code);
            issue(1'b0, 1'b0, 1'b1, tv[i].col, tv[i].row);
            watch(tv[i].valid != 0 ? 1 : 3, 75, tv[i].col, tv[i].row, tv[i].code, -1);
            if (tv[i].valid != 0) begin
                check($sformatf("tile%0d_busy1", i), busy_at1, 1);
                check($sformatf("tile%0d_map", i), map_at1, tv[i].exp_map);
                check($sformatf("tile%0d_sel", i), sel_at3, tv[i].code);
                check($sformatf("tile%0d_nplot", i), nplot, 64);
                check($sformatf("tile%0d_bad", i), nbad, 0);
                check($sformatf("tile%0d_done_cyc", i), done_cyc, 68);
                check($sformatf("tile%0d_ndone", i), ndone, 1);
            end else begin
                check($sformatf("tile%0d_busy1", i), busy_at1, 0);
                check($sformatf("tile%0d_nplot", i), nplot, 0);
                check($sformatf("tile%0d_ndone", i), ndone, 0);
            end
            check($sformatf("tile%0d_busy_end", i), int'(busy), 0);
        end

        // Out-of-range tile immediately followed by a valid one
        map_mem[2 * 20 + 3] = 2'd1;
        tile_req = 1'b1; tile_col = 5'd20; tile_row = 4'd0;
        @(negedge clock);
        check("inv_busy", int'(busy), 0);
        tile_col = 5'd3; tile_row = 4'd2;
        @(negedge clock);
        tile_req = 1'b0;
        watch(1, 75, 3, 2, 1, -1);
        check("inv_next_busy1", busy_at1, 1);
        check("inv_next_nplot", nplot, 64);
        check("inv_next_bad", nbad, 0);
        check("inv_next_done_cyc", done_cyc, 68);

        // Whole board
        for (int i = 0; i < 300; i++) map_mem[i] = 2'(((i / 20) + (i % 20)) % 4);
        for (int i = 0; i < 19200; i++) seen[i] = 1'b0;
        issue(1'b0, 1'b1, 1'b0, 0, 0);
        watch(2, 19810, 0, 0, 0, -1);
        check("brd_map1", map_at1, 0);
        check("brd_nplot", nplot, 19200);
        check("brd_bad", nbad, 0);
        check("brd_dup", ndup, 0);
        check("brd_sel", nsel_bad, 0);
        check("brd_done_cyc", done_cyc, 19802);
        check("brd_ndone", ndone, 1);

        // All three strobes together, plus a tile_req while busy
        issue(1'b1, 1'b1, 1'b1, 4, 4);
        watch(0, 19300, 0, 0, 0, 100);
        tile_req = 1'b0;
        check("pri_nplot", nplot, 19200);
        check("pri_bad", nbad, 0);
        check("pri_ndone", ndone, 1);
        check("pri_done_cyc", done_cyc, 19202);

        // Reset in the middle of a board redraw
        issue(1'b0, 1'b1, 1'b0, 0, 0);
        watch(2, 499, 0, 0, 0, -1);
        check("mid_busy", int'(busy), 1);
        reset = 1'b1;
        #1;
        check_zero("mid_rst");
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("post_rst_done", int'(done), 0);
        check("post_rst_busy", int'(busy), 0);
        issue(1'b1, 1'b0, 1'b0, 0, 0);
        watch(0, 20, 0, 0, 0, -1);
        check("post_scr_addr1", scr_at1, 0);
        check("post_scr_nplot", nplot, 19);
        check("post_scr_bad", nbad, 0);
        check("post_scr_ndone", ndone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
